// File: rtl/alu_div_unit.sv
// rtl/alu_div_unit.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
// Holds its own iteration down-counter; one quotient bit per clock, then a sign fix-up cycle.

module alu_div_cnt #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);
endmodule

module alu_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [XLEN-1:0] L_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          r_state, w_next;
  logic [1:0]      r_op;
  logic [XLEN-1:0] r_rem, r_quo, r_dvsr, r_result;
  logic            r_neg_q, r_neg_r, r_done;

  logic            w_go, w_signed, w_dvd_neg, w_dvs_neg, w_div0, w_ovf;
  logic [XLEN-1:0] w_dvd_abs, w_dvs_abs, w_rem_nxt, w_quo_nxt, w_sel, w_fix;
  logic [XLEN:0]   w_shift, w_diff;
  logic [CNT_W-1:0] w_cnt;
  logic            w_cnt_zero, w_neg;

  assign w_go      = (r_state == IDLE) && start && !kill;
  assign w_signed  = ~op[0];
  assign w_dvd_neg = w_signed & dividend[XLEN-1];
  assign w_dvs_neg = w_signed & divisor[XLEN-1];
  assign w_dvd_abs = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_abs = w_dvs_neg ? -divisor : divisor;
  assign w_div0    = (divisor == '0);
  assign w_ovf     = w_signed && (dividend == L_MIN) && (&divisor);

  alu_div_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_go),
    .i_load_val (CNT_W'(XLEN-1)),
    .i_dec      ((r_state == CALC) && !kill),
    .o_cnt      (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  // Trial subtract is one bit wider so its MSB is the borrow (negative result).
  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_dvsr};
  assign w_rem_nxt = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], ~w_diff[XLEN]};

  assign w_sel = r_op[1] ? r_rem : r_quo;
  assign w_neg = r_op[1] ? r_neg_r : r_neg_q;
  assign w_fix = w_neg ? -w_sel : w_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_go) w_next = (w_div0 || w_ovf) ? FIX : CALC;
      CALC:    if (w_cnt_zero) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (kill) w_next = IDLE;
  end

  // Special cases park their preset in the quo/rem slot that FIX will select, with no negation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op     <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!kill) begin
        case (r_state)
          IDLE: if (start) begin
            r_op <= op;
            if (w_div0) begin
              r_quo   <= '1;
              r_rem   <= dividend;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else if (w_ovf) begin
              r_quo   <= L_MIN;
              r_rem   <= '0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else begin
              r_quo   <= w_dvd_abs;
              r_rem   <= '0;
              r_dvsr  <= w_dvs_abs;
              r_neg_q <= w_dvd_neg ^ w_dvs_neg;
              r_neg_r <= w_dvd_neg;
            end
          end
          CALC: begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
          end
          FIX: begin
            r_result <= w_fix;
            r_done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = r_done;
  assign result = r_result;
endmodule

// File: doc/alu_div_unit.md
Name: alu_div_unit

Overview:
- Iterative radix-2 restoring divider executing RV32M DIV/DIVU/REM/REMU in the ALU execute stage.
- Consumer of the 5-bit iteration down-counter: holds one internal instance, loaded with XLEN-1 at operation start and decremented once per iteration.
- Produces one quotient bit per clock, applies sign fix-up, and returns the result to writeback with a start/busy/done handshake.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 5, iteration counter width; must equal log2(XLEN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- start  in  1  launch request; sampled only while busy=0.
- kill  in  1  pipeline flush; aborts any operation in flight.
- op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  in  XLEN  rs1 value.
- divisor  in  XLEN  rs2 value.
- busy  out  1  operation in flight; start ignored.
- done  out  1  one-cycle pulse; result valid.
- result  out  XLEN  quotient or remainder, held until next done.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, result=0; counter, remainder, quotient and sign registers cleared. Reset asserted mid-operation discards it; no done is produced.
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1, kill=0, at edge E0:
  - Latch op.
  - Signed ops: latch |dividend| and |divisor|, plus sign flags. Quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend).
  - Unsigned ops: latch operands as-is.
  - Clear partial remainder; load counter with XLEN-1; go to CALC.
- Divisor==0 at E0 (special case): go directly to FIX with a preset result.
  - DIV/DIVU: all ones.
  - REM/REMU: dividend, unmodified.
- Signed overflow (DIV/REM, dividend=0x80000000, divisor=0xFFFFFFFF) at E0: go directly to FIX with a preset result.
  - DIV: 0x80000000.
  - REM: 0.
- CALC, one iteration per edge:
  - Shift {rem, quo} left by 1.
  - Trial-subtract divisor from rem using an XLEN+1-bit subtract.
  - If non-negative: keep the difference and set quo[0]=1; otherwise restore rem and set quo[0]=0.
  - Decrement the counter.
  - The iteration performed while counter==0 is the last one (XLEN iterations total); the same edge moves to FIX.
  - Counter wrap-around is never used.
- FIX, one edge:
  - result = selected quotient or remainder, negated if its sign flag is set (signed ops only).
  - done=1 for exactly this one cycle; busy=0 on the same edge; return to IDLE.
- Latency, measured from start edge E0:
  - Normal operations: iterations at E1..E32, done registered at E33.
  - Zero-divisor and overflow: done registered at E1.
- busy: 1 from E0 until the edge that raises done.
- done and result are registered; result is stable from done until the next done.
- Back-to-back: start asserted during the done cycle is accepted (busy=0 then).
- start while busy=1: ignored; operands are not re-sampled.
- kill (priority below reset, above everything else): any state returns to IDLE at the next edge; busy=0; done is suppressed; result is unchanged.
- kill together with start in IDLE: start is ignored.
- Operand inputs need only be valid at E0.

Test Plan:
- DIV 100 / 7: done at E33 (done in cycle 33) -> result=14, busy high for 33 cycles; REM 100 % 7 -> 2.
- Signed sign rules: DIV -7 / 2 -> 0xFFFFFFFD (-3); REM -7 % 2 -> 0xFFFFFFFF (-1); REM 7 % -2 -> 1; DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF.
- Divide by zero: DIVU 5 / 0 -> 0xFFFFFFFF with done at E1; REM 5 % 0 -> 5; DIV -1 / 0 -> 0xFFFFFFFF.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at E1; REM same operands -> 0.
- Handshake:
  - start held through an operation -> exactly one done.
  - New start in the done cycle (DIVU 9/3) -> result 3 at the next E33.
  - start while busy -> ignored.
- Abort:
  - kill at iteration 10 -> busy=0 next cycle, no done, result unchanged.
  - reset asserted mid-CALC -> busy=0, done=0, result=0 asynchronously; a following operation is correct.
